// File: rtl/step_motor_ctrl.sv
// Wishbone-mapped stepper pulse generator: programmable period/pulse/steps,
// signed position tracking, limit-switch abort and DONE interrupt.
module step_motor_ctrl #(
  parameter int PER_W = 16,
  parameter int CNT_W = 16,
  parameter int POS_W = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [2:0]  wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic [31:0] wbs_dat_o,
  output logic        wbs_ack_o,
  input  logic        limit_n,
  output logic        motor_step,
  output logic        motor_dir,
  output logic        motor_en_n,
  output logic        irq
);

  localparam logic [2:0] A_CTRL   = 3'd0;
  localparam logic [2:0] A_PERIOD = 3'd1;
  localparam logic [2:0] A_PULSE  = 3'd2;
  localparam logic [2:0] A_STEPS  = 3'd3;
  localparam logic [2:0] A_STATUS = 3'd4;
  localparam logic [2:0] A_POS    = 3'd5;

  typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW} state_t;

  state_t             state_reg, state_next;
  logic [PER_W-1:0]   cnt_reg, cnt_next;
  logic               abort_pend_reg, abort_pend_next;
  logic               step_reg;
  logic [CNT_W-1:0]   rem_reg;
  logic               cont_reg;
  logic               run_dir_reg;
  logic [POS_W-1:0]   pos_reg;

  logic               en_reg, dir_reg, irq_en_reg;
  logic [PER_W-1:0]   period_reg, pulse_reg;
  logic [CNT_W-1:0]   steps_reg;
  logic               done_reg, aborted_reg;
  logic               start_pend_reg, stop_pend_reg;
  logic               lim_meta_reg, lim_sync_reg;
  logic               ack_reg;
  logic [31:0]        dat_reg;

  logic               enter_high, move_start, end_move, end_abort, start_reject;
  logic               abort_req, limit, busy;
  logic [PER_W-1:0]   per_eff, pul_eff;

  // Byte-lane write mask
  logic [31:0] wmask;
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_mask
      assign wmask[gi*8 +: 8] = {8{wbs_sel_i[gi]}};
    end
  endgenerate

  function automatic logic [31:0] merge(input logic [31:0] old_val,
                                        input logic [31:0] new_val,
                                        input logic [31:0] mask);
    merge = (old_val & ~mask) | (new_val & mask);
  endfunction

  logic wb_req, wb_wr, wb_rd;
  assign wb_req = wbs_cyc_i & wbs_stb_i & ~ack_reg;
  assign wb_wr  = wb_req & wbs_we_i;
  assign wb_rd  = wb_req & ~wbs_we_i;

  logic [31:0] ctrl_m, period_m, pulse_m, steps_m, pos_m;
  assign ctrl_m   = merge({27'd0, irq_en_reg, 2'b00, dir_reg, en_reg}, wbs_dat_i, wmask);
  assign period_m = merge(32'(period_reg), wbs_dat_i, wmask);
  assign pulse_m  = merge(32'(pulse_reg), wbs_dat_i, wmask);
  assign steps_m  = merge(32'(steps_reg), wbs_dat_i, wmask);
  assign pos_m    = merge(32'(pos_reg), wbs_dat_i, wmask);

  logic wr_ctrl, start_wr, stop_wr, st_wr;
  assign wr_ctrl  = wb_wr && (wbs_adr_i == A_CTRL);
  assign start_wr = wr_ctrl & wbs_sel_i[0] & wbs_dat_i[2] & ~wbs_dat_i[3];
  assign stop_wr  = wr_ctrl & wbs_sel_i[0] & wbs_dat_i[3];
  assign st_wr    = wb_wr && (wbs_adr_i == A_STATUS) && wbs_sel_i[0];

  assign limit = ~lim_sync_reg;
  assign busy  = (state_reg != S_IDLE);

  // Position is signed; sign-extend it onto the 32-bit bus
  logic signed [POS_W-1:0] pos_s;
  logic [15:0]             rem16;
  assign pos_s = pos_reg;
  assign rem16 = 16'(rem_reg);

  logic [31:0] rdata;
  always_comb begin
    rdata = '0;
    case (wbs_adr_i)
      A_CTRL:   rdata = {27'd0, irq_en_reg, 2'b00, dir_reg, en_reg};
      A_PERIOD: rdata = 32'(period_reg);
      A_PULSE:  rdata = 32'(pulse_reg);
      A_STEPS:  rdata = 32'(steps_reg);
      A_STATUS: rdata = {rem16, 12'd0, aborted_reg, limit, done_reg, busy};
      A_POS:    rdata = 32'(pos_s);
      default:  rdata = '0;
    endcase
  end

  // Clamp the programmed timing into a legal period / high-time pair
  always_comb begin
    per_eff = (period_reg < PER_W'(2)) ? PER_W'(2) : period_reg;
    if (pulse_reg == '0)
      pul_eff = PER_W'(1);
    else if (pulse_reg >= per_eff)
      pul_eff = per_eff - PER_W'(1);
    else
      pul_eff = pulse_reg;
  end

  assign abort_req = stop_pend_reg | ~en_reg | limit;

  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    abort_pend_next = abort_pend_reg;
    enter_high      = 1'b0;
    move_start      = 1'b0;
    end_move        = 1'b0;
    end_abort       = 1'b0;
    start_reject    = 1'b0;
    case (state_reg)
      S_IDLE: begin
        abort_pend_next = 1'b0;
        if (start_pend_reg) begin
          if (en_reg && !limit) begin
            state_next = S_HIGH;
            cnt_next   = pul_eff - PER_W'(1);
            move_start = 1'b1;
            enter_high = 1'b1;
          end else begin
            start_reject = 1'b1;
          end
        end
      end
      S_HIGH: begin
        // A high phase always runs to completion; remember any abort for its end
        if (abort_req)
          abort_pend_next = 1'b1;
        if (cnt_reg == '0) begin
          if (abort_req || abort_pend_reg) begin
            state_next = S_IDLE;
            end_abort  = 1'b1;
          end else begin
            state_next = S_LOW;
            cnt_next   = per_eff - pul_eff - PER_W'(1);
          end
        end else begin
          cnt_next = cnt_reg - PER_W'(1);
        end
      end
      S_LOW: begin
        if (abort_req) begin
          state_next = S_IDLE;
          end_abort  = 1'b1;
        end else if (cnt_reg == '0) begin
          if (!cont_reg && rem_reg == '0) begin
            state_next = S_IDLE;
            end_move   = 1'b1;
          end else begin
            state_next = S_HIGH;
            cnt_next   = pul_eff - PER_W'(1);
            enter_high = 1'b1;
          end
        end else begin
          cnt_next = cnt_reg - PER_W'(1);
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= S_IDLE;
      cnt_reg        <= '0;
      abort_pend_reg <= 1'b0;
      step_reg       <= 1'b0;
      rem_reg        <= '0;
      cont_reg       <= 1'b0;
      run_dir_reg    <= 1'b0;
      pos_reg        <= '0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      abort_pend_reg <= abort_pend_next;
      step_reg       <= (state_next == S_HIGH);
      if (move_start) begin
        cont_reg    <= (steps_reg == '0);
        run_dir_reg <= dir_reg;
        rem_reg     <= (steps_reg == '0) ? '0 : steps_reg - CNT_W'(1);
      end else if (enter_high && !cont_reg && rem_reg != '0) begin
        rem_reg <= rem_reg - CNT_W'(1);
      end
      if (enter_high) begin
        if (move_start ? dir_reg : run_dir_reg)
          pos_reg <= pos_reg + POS_W'(1);
        else
          pos_reg <= pos_reg - POS_W'(1);
      end else if (wb_wr && wbs_adr_i == A_POS && !busy) begin
        pos_reg <= pos_m[POS_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_reg        <= 1'b0;
      dat_reg        <= '0;
      en_reg         <= 1'b0;
      dir_reg        <= 1'b0;
      irq_en_reg     <= 1'b0;
      period_reg     <= '0;
      pulse_reg      <= '0;
      steps_reg      <= '0;
      done_reg       <= 1'b0;
      aborted_reg    <= 1'b0;
      start_pend_reg <= 1'b0;
      stop_pend_reg  <= 1'b0;
      // Synchroniser resets to "switch released" so no phantom limit follows reset
      lim_meta_reg   <= 1'b1;
      lim_sync_reg   <= 1'b1;
    end else begin
      ack_reg        <= wb_req;
      dat_reg        <= wb_rd ? rdata : '0;
      start_pend_reg <= start_wr;
      stop_pend_reg  <= stop_wr;
      lim_meta_reg   <= limit_n;
      lim_sync_reg   <= lim_meta_reg;
      if (wr_ctrl) begin
        en_reg     <= ctrl_m[0];
        dir_reg    <= ctrl_m[1];
        irq_en_reg <= ctrl_m[4];
      end
      if (wb_wr && wbs_adr_i == A_PERIOD) period_reg <= period_m[PER_W-1:0];
      if (wb_wr && wbs_adr_i == A_PULSE)  pulse_reg  <= pulse_m[PER_W-1:0];
      if (wb_wr && wbs_adr_i == A_STEPS)  steps_reg  <= steps_m[CNT_W-1:0];
      // Set has priority over a simultaneous write-one-to-clear
      if (st_wr && wbs_dat_i[1]) done_reg <= 1'b0;
      if (end_move || end_abort) done_reg <= 1'b1;
      if (st_wr && wbs_dat_i[3]) aborted_reg <= 1'b0;
      if (end_abort || start_reject) aborted_reg <= 1'b1;
    end
  end

  assign wbs_ack_o  = ack_reg;
  assign wbs_dat_o  = dat_reg;
  assign motor_step = step_reg;
  assign motor_dir  = run_dir_reg;
  assign motor_en_n = ~en_reg;
  assign irq        = irq_en_reg & done_reg;

endmodule

// File: tb/tb_step_motor_ctrl.sv
// Randomized and directed bench for step_motor_ctrl; pulse timing and
// position are compared against a simple arithmetic model of each move.
module tb_step_motor_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [2:0]  wbs_adr_i;
  logic [31:0] wbs_dat_i, wbs_dat_o;
  logic        wbs_ack_o;
  logic        limit_n;
  logic        motor_step, motor_dir, motor_en_n, irq;

  int vectors = 0;
  int miscompares = 0;

  step_motor_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
    .wbs_dat_o(wbs_dat_o), .wbs_ack_o(wbs_ack_o),
    .limit_n(limit_n), .motor_step(motor_step), .motor_dir(motor_dir),
    .motor_en_n(motor_en_n), .irq(irq)
  );

  always #5 clk = ~clk;

  // Pulse monitor: records every high time and every low gap between pulses
  int rises = 0, hi_cnt = 0, lo_cnt = 0;
  int clr_req = 0, clr_seen = 0;
  bit prev_step = 1'b0;
  int hi_q[$];
  int lo_q[$];

  always @(negedge clk) begin
    if (clr_req != clr_seen) begin
      clr_seen = clr_req;
      rises = 0;
      hi_q.delete();
      lo_q.delete();
    end
    if (motor_step && !prev_step) begin
      rises++;
      if (rises > 1) lo_q.push_back(lo_cnt);
      hi_cnt = 1;
    end else if (motor_step) begin
      hi_cnt++;
    end else if (prev_step) begin
      hi_q.push_back(hi_cnt);
      lo_cnt = 1;
    end else begin
      lo_cnt++;
    end
    prev_step = motor_step;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    clr_req++;
    @(negedge clk);
    #1;
  endtask

  task automatic wb_write(input logic [2:0] a, input logic [31:0] d, input logic [3:0] s = 4'hF);
    @(negedge clk);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1;
    wbs_adr_i = a; wbs_dat_i = d; wbs_sel_i = s;
    @(posedge clk);
    #1;
    @(negedge clk);
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
  endtask

  task automatic wb_read(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0;
    wbs_adr_i = a; wbs_sel_i = 4'hF;
    @(posedge clk);
    #1;
    d = wbs_dat_o;
    @(negedge clk);
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
  endtask

  task automatic wait_idle();
    logic [31:0] st;
    st = 32'h1;
    for (int i = 0; i < 3000; i++) begin
      wb_read(3'd4, st);
      if (!st[0]) break;
    end
    if (st[0]) check("idle_timeout", st[0], 1'b0);
  endtask

  task automatic wait_rises(input int n);
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      if (rises >= n) break;
    end
    if (rises < n) check("rise_timeout", rises, n);
  endtask

  // One finite move, checked against the clamped timing and wrapped position
  task automatic run_move(input int per, input int pul, input int steps,
                          input bit dir, input logic [31:0] pos0, input bit use_irq);
    int pe, ue;
    logic [31:0] exp_pos, rd;
    pe = (per < 2) ? 2 : per;
    ue = (pul == 0) ? 1 : ((pul >= pe) ? pe - 1 : pul);
    exp_pos = dir ? pos0 + 32'(steps) : pos0 - 32'(steps);
    clear_mon();
    wb_write(3'd1, 32'(per));
    wb_write(3'd2, 32'(pul));
    wb_write(3'd3, 32'(steps));
    wb_write(3'd5, pos0);
    wb_write(3'd0, 32'h5 | (32'(dir) << 1) | (32'(use_irq) << 4));
    wait_idle();
    repeat (2) @(posedge clk);
    $display("move per=%0d pul=%0d steps=%0d dir=%0d -> rises=%0d", per, pul, steps, dir, rises);
    check("pulse_count", rises, steps);
    check("high_count", hi_q.size(), steps);
    check("low_count", lo_q.size(), steps - 1);
    foreach (hi_q[i]) check("high_time", hi_q[i], ue);
    foreach (lo_q[i]) check("low_time", lo_q[i], pe - ue);
    wb_read(3'd5, rd);
    check("pos", rd, exp_pos);
    wb_read(3'd4, rd);
    check("status_done", rd, 32'h2);
    check("dir_pin", motor_dir, dir);
    check("irq_after_move", irq, use_irq);
    wb_write(3'd4, 32'hA);
    #2;
    check("irq_cleared", irq, 1'b0);
  endtask

  initial begin
    logic [31:0] rd;
    int r0, r1;
    rst_n = 1'b0; limit_n = 1'b1;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    wbs_sel_i = 4'h0; wbs_adr_i = 3'd0; wbs_dat_i = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_step", motor_step, 1'b0);
    check("rst_en_n", motor_en_n, 1'b1);
    check("rst_dir", motor_dir, 1'b0);
    check("rst_irq", irq, 1'b0);
    check("rst_ack", wbs_ack_o, 1'b0);
    check("rst_dat", wbs_dat_o, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    wb_read(3'd0, rd); check("rst_ctrl", rd, 32'h0);
    wb_read(3'd4, rd); check("rst_status", rd, 32'h0);
    wb_read(3'd5, rd); check("rst_pos", rd, 32'h0);

    // Byte-enable honoured on a partial write
    wb_write(3'd1, 32'hFFFF, 4'b0001);
    wb_read(3'd1, rd); check("sel_period", rd, 32'h00FF);

    run_move(10, 3, 4, 1'b1, 32'd0, 1'b0);
    run_move(10, 3, 4, 1'b0, 32'd2, 1'b0);
    run_move(1, 0, 3, 1'b1, 32'd7, 1'b0);
    run_move(10, 20, 3, 1'b0, 32'd0, 1'b0);
    run_move(4, 2, 2, 1'b1, 32'hFFFF_FFFF, 1'b1);
    for (int k = 0; k < 6; k++)
      run_move($urandom_range(0, 14), $urandom_range(0, 18), $urandom_range(1, 6),
               1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));

    // Continuous move stopped after the fifth pulse; POS write while busy ignored
    clear_mon();
    wb_write(3'd1, 32'd10); wb_write(3'd2, 32'd3); wb_write(3'd3, 32'd0);
    wb_write(3'd5, 32'd100);
    wb_write(3'd0, 32'h7);
    wb_write(3'd5, 32'h1234);
    wait_rises(5);
    wb_write(3'd0, 32'hB);
    wait_idle();
    repeat (20) @(posedge clk);
    $display("continuous stop -> rises=%0d", rises);
    check("cont_rises", rises, 5);
    wb_read(3'd5, rd); check("cont_pos", rd, 32'd105);
    wb_read(3'd4, rd); check("cont_status", rd, 32'hA);
    wb_write(3'd4, 32'hA);

    // Limit switch mid-move
    clear_mon();
    wb_write(3'd2, 32'd4); wb_write(3'd5, 32'd0);
    wb_write(3'd0, 32'h5);
    wait_rises(3);
    @(negedge clk);
    limit_n = 1'b0;
    r0 = rises;
    repeat (8) @(posedge clk);
    r1 = rises;
    repeat (40) @(posedge clk);
    #1;
    $display("limit abort -> rises=%0d", rises);
    check("limit_no_more", rises, r1);
    check("limit_bound", (r1 <= r0 + 1), 1'b1);
    check("limit_step_low", motor_step, 1'b0);
    wb_read(3'd4, rd); check("limit_status", rd, 32'hE);
    wb_read(3'd5, rd); check("limit_pos", rd, 32'(-r1));
    wb_write(3'd4, 32'hA);
    wb_write(3'd0, 32'h5);
    repeat (30) @(posedge clk);
    check("limit_start_none", rises, r1);
    wb_read(3'd4, rd); check("limit_start_status", rd, 32'hC);
    limit_n = 1'b1;
    repeat (5) @(posedge clk);
    wb_write(3'd4, 32'hA);
    wb_read(3'd4, rd); check("limit_released", rd, 32'h0);

    // Unmapped reads and single-cycle ack
    wb_read(3'd6, rd); check("unmapped6", rd, 32'h0);
    wb_read(3'd7, rd); check("unmapped7", rd, 32'h0);
    @(negedge clk);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = 3'd0;
    @(posedge clk); #1; check("ack_high", wbs_ack_o, 1'b1);
    @(posedge clk); #1; check("ack_pulse", wbs_ack_o, 1'b0);
    @(negedge clk);
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;

    // Reset mid-move
    wb_write(3'd3, 32'd0);
    wb_write(3'd0, 32'h7);
    wait_rises(1);
    for (int i = 0; i < 50 && !motor_step; i++) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_step", motor_step, 1'b0);
    check("midrst_en_n", motor_en_n, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    wb_read(3'd5, rd); check("midrst_pos", rd, 32'h0);
    wb_read(3'd4, rd); check("midrst_status", rd, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
